// File: rtl/stim_seq_pkg.sv
// Shared types, widths and corner-pattern helper for the stimulus sequencer.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORNER,
    ST_RAND,
    ST_DONE
  } stim_state_e;

  localparam int SMALL_W = 32;
  localparam int QUAD_W  = 40;
  localparam int WIDE_W  = 70;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // idx 0: zeros, 1: all-ones, 2: MSB only, 3: all-ones except MSB (low `width` bits).
  function automatic logic [WIDE_W-1:0] corner_vec(input logic [1:0] idx, input int width);
    logic [WIDE_W-1:0] ones;
    logic [WIDE_W-1:0] msb;
    ones = '0;
    msb  = '0;
    for (int i = 0; i < WIDE_W; i++) begin
      if (i < width) ones[i] = 1'b1;
      if (i == width - 1) msb[i] = 1'b1;
    end
    case (idx)
      2'd0:    corner_vec = '0;
      2'd1:    corner_vec = ones;
      2'd2:    corner_vec = msb;
      default: corner_vec = ones & ~msb;
    endcase
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous reload of a fixed seed.
module stim_lfsr32
  import stim_seq_pkg::*;
#(
  parameter logic [31:0] SEED_VAL = 32'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] state
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_VAL;
    end else if (adv) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED_VAL;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/stim_seq.sv
// Stimulus sequencer: corner burst then LFSR run, checking out_* == in_* + 1.
// Response checking is built only when STIM_SEQ_CHECK_EN is defined.
module stim_seq
  import stim_seq_pkg::*;
#(
  parameter int          NUM_RAND = 64,
  parameter logic [31:0] SEED     = 32'hACE1_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [SMALL_W-1:0] in_small,
  output logic [QUAD_W-1:0]  in_quad,
  output logic [WIDE_W-1:0]  in_wide,
  output logic               vec_valid,
  input  logic [QUAD_W-1:0]  out_quad,
  input  logic [WIDE_W-1:0]  out_wide,
  output logic               busy,
  output logic               done,
  output logic [15:0]        vec_count,
  output logic [15:0]        err_count,
  output logic [15:0]        first_err_idx
);

  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] NUM_RAND_W = 16'(NUM_RAND);

  stim_state_e        state_q, state_d;
  logic [1:0]         corner_idx_q, corner_idx_d;
  logic [15:0]        rand_cnt_q, rand_cnt_d;
  logic [SMALL_W-1:0] in_small_q, in_small_d;
  logic [QUAD_W-1:0]  in_quad_q, in_quad_d;
  logic [WIDE_W-1:0]  in_wide_q, in_wide_d;
  logic               vec_valid_q, vec_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        vec_count_q, vec_count_d;
  logic               lfsr_load, lfsr_adv, seq_clear;
  logic [31:0]        lfsr_state;
  logic [1:0]         corner_sel;

  stim_lfsr32 #(.SEED_VAL(SEED_EFF)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  // The registered outputs carry the vector for the coming cycle, so the
  // corner index looked up here is the one after the vector now presented.
  assign corner_sel = (state_q == ST_CORNER) ? corner_idx_q + 2'd1 : 2'd0;

  always_comb begin
    state_d      = state_q;
    corner_idx_d = corner_idx_q;
    rand_cnt_d   = rand_cnt_q;
    in_small_d   = in_small_q;
    in_quad_d    = in_quad_q;
    in_wide_d    = in_wide_q;
    vec_valid_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    seq_clear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = (state_q == ST_DONE);
        if (start) begin
          seq_clear    = 1'b1;
          lfsr_load    = 1'b1;
          corner_idx_d = 2'd0;
          in_small_d   = SMALL_W'(corner_vec(corner_sel, SMALL_W));
          in_quad_d    = QUAD_W'(corner_vec(corner_sel, QUAD_W));
          in_wide_d    = corner_vec(corner_sel, WIDE_W);
          vec_valid_d  = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          state_d      = ST_CORNER;
        end
      end
      ST_CORNER: begin
        vec_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (corner_idx_q == 2'd3) begin
          in_small_d = lfsr_state;
          in_quad_d  = {lfsr_state[7:0], lfsr_state};
          in_wide_d  = {lfsr_state[5:0], lfsr_state, lfsr_state};
          lfsr_adv   = 1'b1;
          rand_cnt_d = 16'd1;
          state_d    = ST_RAND;
        end else begin
          corner_idx_d = corner_idx_q + 2'd1;
          in_small_d   = SMALL_W'(corner_vec(corner_sel, SMALL_W));
          in_quad_d    = QUAD_W'(corner_vec(corner_sel, QUAD_W));
          in_wide_d    = corner_vec(corner_sel, WIDE_W);
        end
      end
      ST_RAND: begin
        if (rand_cnt_q == NUM_RAND_W) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          vec_valid_d = 1'b1;
          busy_d      = 1'b1;
          in_small_d  = lfsr_state;
          in_quad_d   = {lfsr_state[7:0], lfsr_state};
          in_wide_d   = {lfsr_state[5:0], lfsr_state, lfsr_state};
          lfsr_adv    = 1'b1;
          rand_cnt_d  = rand_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_count_d = vec_count_q;
    if (seq_clear) vec_count_d = 16'd0;
    else if (vec_valid_q && vec_count_q != 16'hFFFF) vec_count_d = vec_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      corner_idx_q <= 2'd0;
      rand_cnt_q   <= 16'd0;
      in_small_q   <= '0;
      in_quad_q    <= '0;
      in_wide_q    <= '0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vec_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      corner_idx_q <= corner_idx_d;
      rand_cnt_q   <= rand_cnt_d;
      in_small_q   <= in_small_d;
      in_quad_q    <= in_quad_d;
      in_wide_q    <= in_wide_d;
      vec_valid_q  <= vec_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vec_count_q  <= vec_count_d;
    end
  end

`ifdef STIM_SEQ_CHECK_EN
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] first_err_idx_q, first_err_idx_d;
  logic        mismatch;

  always_comb begin
    mismatch = vec_valid_q && ((out_quad != in_quad_q + QUAD_W'(1)) ||
                               (out_wide != in_wide_q + WIDE_W'(1)));
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    if (seq_clear) begin
      err_count_d     = 16'd0;
      first_err_idx_d = 16'hFFFF;
    end else if (mismatch) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (err_count_q == 16'd0) first_err_idx_d = vec_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q     <= 16'd0;
      first_err_idx_q <= 16'hFFFF;
    end else begin
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
`else
  logic unused_resp;
  assign unused_resp   = ^{out_quad, out_wide};
  assign err_count     = 16'd0;
  assign first_err_idx = 16'hFFFF;
`endif

  assign in_small  = in_small_q;
  assign in_quad   = in_quad_q;
  assign in_wide   = in_wide_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_stim_seq.sv
// Scoreboard bench for stim_seq: expected vectors queued at start, monitor pops per valid cycle.
module tb_stim_seq;

  localparam int          NR   = 8;
  localparam int          NV   = 4 + NR;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  typedef struct {
    int          idx;
    logic [31:0] s;
    logic [39:0] q;
    logic [69:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_small;
  logic [39:0] in_quad;
  logic [69:0] in_wide;
  logic        vec_valid;
  logic [39:0] out_quad;
  logic [69:0] out_wide;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;
  logic [15:0] fault_q_mask;
  logic [15:0] fault_w_mask;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  vec_t last_exp;
  vec_t mon_e;

  always #5 clk = ~clk;

  // Incrementer model with optional stuck-at-input faults on chosen vectors.
  assign out_quad = (vec_valid && vec_count < 16'd16 && fault_q_mask[vec_count[3:0]]) ? in_quad : in_quad + 40'd1;
  assign out_wide = (vec_valid && vec_count < 16'd16 && fault_w_mask[vec_count[3:0]]) ? in_wide : in_wide + 70'd1;

  stim_seq #(.NUM_RAND(NR), .SEED(SEED)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_small      (in_small),
    .in_quad       (in_quad),
    .in_wide       (in_wide),
    .vec_valid     (vec_valid),
    .out_quad      (out_quad),
    .out_wide      (out_wide),
    .busy          (busy),
    .done          (done),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic push_expected();
    vec_t        v;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      v.idx = k;
      case (k)
        0: begin v.s = 32'h0;         v.q = 40'h0;             v.w = 70'h0; end
        1: begin v.s = 32'hFFFF_FFFF; v.q = 40'hFF_FFFF_FFFF;  v.w = 70'h3F_FFFF_FFFF_FFFF_FFFF; end
        2: begin v.s = 32'h8000_0000; v.q = 40'h80_0000_0000;  v.w = 70'h20_0000_0000_0000_0000; end
        default: begin v.s = 32'h7FFF_FFFF; v.q = 40'h7F_FFFF_FFFF; v.w = 70'h1F_FFFF_FFFF_FFFF_FFFF; end
      endcase
      exp_q.push_back(v);
    end
    r = SEED;
    for (int i = 0; i < NR; i++) begin
      v.idx = 4 + i;
      v.s   = r;
      v.q   = {r[7:0], r};
      v.w   = {r[5:0], r, r};
      exp_q.push_back(v);
      r = lfsr_next(r);
    end
    last_exp = v;
  endtask

  always @(negedge clk) begin
    if (vec_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_vec: got vector at vec_count=%0d, required none", vec_count);
      end else begin
        mon_e = exp_q.pop_front();
        tests++;
        if (in_small !== mon_e.s || in_quad !== mon_e.q || in_wide !== mon_e.w ||
            vec_count !== 16'(mon_e.idx) || busy !== 1'b1) begin
          fails++;
          $display("FAIL vector_%0d: got cnt=%0d s=%h q=%h w=%h busy=%b, required cnt=%0d s=%h q=%h w=%h busy=1",
                   mon_e.idx, vec_count, in_small, in_quad, in_wide, busy, mon_e.idx, mon_e.s, mon_e.q, mon_e.w);
        end else begin
          $display("[TB] vec %0d s=%h q=%h w=%h ok", mon_e.idx, in_small, in_quad, in_wide);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_small"}, 70'(in_small), 70'd0);
    check({tag, "_in_quad"}, 70'(in_quad), 70'd0);
    check({tag, "_in_wide"}, in_wide, 70'd0);
    check({tag, "_flags"}, 70'({vec_valid, busy, done}), 70'd0);
    check({tag, "_vec_count"}, 70'(vec_count), 70'd0);
    check({tag, "_err_count"}, 70'(err_count), 70'd0);
    check({tag, "_first_err_idx"}, 70'(first_err_idx), 70'hFFFF);
  endtask

  // Called at posedge+2; runs one full sequence and checks the DONE state.
  task automatic run_seq(input logic [15:0] fq, input logic [15:0] fw, input bit poke_start);
    int busy_cycles;
    int cyc;
    int nerr;
    int first;
    fault_q_mask = fq;
    fault_w_mask = fw;
    push_expected();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    busy_cycles = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cycles++;
      start = poke_start && (busy === 1'b1) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #2;
      cyc++;
    end
    start = 1'b0;
    nerr  = 0;
    first = 16'hFFFF;
`ifdef STIM_SEQ_CHECK_EN
    for (int i = 0; i < NV; i++) begin
      if (fq[i] || fw[i]) begin
        nerr++;
        if (first == 16'hFFFF) first = i;
      end
    end
`endif
    check("done_reached", 70'(done), 70'd1);
    check("busy_cycles", 70'(busy_cycles), 70'(NV));
    check("done_flags", 70'({vec_valid, busy}), 70'd0);
    check("done_vec_count", 70'(vec_count), 70'(NV));
    check("done_err_count", 70'(err_count), 70'(nerr));
    check("done_first_err_idx", 70'(first_err_idx), 70'(first));
    check("done_hold_vec", {in_wide[31:0], in_small, in_quad[39:34]}, {last_exp.w[31:0], last_exp.s, last_exp.q[39:34]});
    check("scoreboard_empty", 70'(exp_q.size()), 70'd0);
    exp_q.delete();
    fault_q_mask = '0;
    fault_w_mask = '0;
    $display("[TB] sequence done fq=%h fw=%h err=%0d first=%0d", fq, fw, err_count, first_err_idx);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    fault_q_mask = '0;
    fault_w_mask = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      check("idle_no_start", 70'({done, busy, vec_valid, first_err_idx}), 70'({3'b000, 16'hFFFF}));
    end

    run_seq(16'h0000, 16'h0000, 1'b0);
    run_seq(16'h0000, 16'h0020, 1'b0);
    run_seq(16'h0002, 16'h0000, 1'b1);
    for (int t = 0; t < 6; t++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #2;
        check("done_idle_hold", 70'({done, busy}), 70'b10);
      end
      run_seq(16'($urandom & $urandom & 32'h0FFF), 16'($urandom & $urandom & $urandom & 32'h0FFF), 1'b1);
    end

    // Reset while vector 3 is on the bus, then a clean rerun.
    push_expected();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (!(vec_valid === 1'b1 && vec_count == 16'd3) && cyc < 50) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("midreset_reached_vec3", 70'(vec_count), 70'd3);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("midreset_async");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset_release");
    run_seq(16'h0000, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stim_seq.md
Name: stim_seq

Overview:
- Upstream stimulus sequencer for the top-level increment datapath.
- Drives in_small, in_quad and in_wide with a fixed corner-case burst, then a pseudo-random run.
- Samples the returned out_quad and out_wide on the same cycle and checks each against input + 1.
- Reports progress, completion and an error count to the simulation harness.

Parameters:
- NUM_RAND, 64, number of LFSR vectors after the corner burst (1..65535).
- SEED, 32'hACE1_0001, LFSR seed; a value of 0 is replaced by 32'h1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a sequence from IDLE or DONE.
- in_small  out  32  stimulus to DUT in_small.
- in_quad  out  40  stimulus to DUT in_quad.
- in_wide  out  70  stimulus to DUT in_wide.
- vec_valid  out  1  high while a vector is presented on in_*.
- out_quad  in  40  DUT response, combinational from in_quad.
- out_wide  in  70  DUT response, combinational from in_wide.
- busy  out  1  high in CORNER or RAND.
- done  out  1  high in DONE.
- vec_count  out  16  vectors issued since the last start.
- err_count  out  16  saturating mismatch count.
- first_err_idx  out  16  vec_count value at the first mismatch; 16'hFFFF if none.

Behaviour:
- Reset values: in_*=0, vec_valid=0, busy=0, done=0, vec_count=0, err_count=0, first_err_idx=16'hFFFF, LFSR=SEED (or 1), state=IDLE.
- All outputs are registered.
- States: IDLE, CORNER, RAND, DONE.
- IDLE: start -> CORNER. Clear vec_count, err_count and first_err_idx; load corner index 0 and reload the LFSR.
- CORNER: one vector per cycle, in order:
  - all-zeros
  - all-ones (carry wraps to zero)
  - MSB-only
  - all-ones except MSB
  - After vector 3 -> RAND.
- RAND: one vector per cycle.
  - Vector bits: in_small=lfsr; in_quad={lfsr[7:0],lfsr}; in_wide={lfsr[5:0],lfsr,lfsr}.
  - LFSR: 32-bit Galois, taps 32,22,2,1, advanced once per issued vector.
  - After NUM_RAND vectors -> DONE.
- DONE: vec_valid=0 and in_* hold their last value. start -> CORNER with the same clears as from IDLE.
- start while busy is ignored.
- vec_valid=1 in every CORNER/RAND cycle. vec_count increments on each valid cycle, saturating at 16'hFFFF.
- Check, on each cycle with vec_valid=1:
  - expected_q = (in_quad + 1) mod 2^40; expected_w = (in_wide + 1) mod 2^70.
  - A mismatch on either width increments err_count by 1 (saturating at 16'hFFFF).
  - On the first mismatch, first_err_idx = vec_count; it is not updated again.
- Latency: a vector and its check occur in the same cycle; the error counters update on the next edge.
- Reset asserted mid-sequence: immediate return to reset values; no partial DONE.

Optional Feature:
- STIM_SEQ_CHECK_EN defined: checker and error registers are present as described above.
- Undefined: no comparison logic; out_quad and out_wide are ignored; err_count is tied to 0 and first_err_idx to 16'hFFFF.

Decomposition:
- Package stim_seq_pkg:
  - State enum stim_state_e.
  - Width constants SMALL_W=32, QUAD_W=40, WIDE_W=70.
  - Constant LFSR_TAPS=32'h8020_0003.
  - Corner-pattern function corner_vec(idx, width).
- One sub-module, stim_lfsr32: seed load, advance enable, 32-bit state output.

Test Plan:
- Reset, no start -> done=0, busy=0, vec_valid=0, first_err_idx=16'hFFFF for 100 cycles.
- Correct DUT, NUM_RAND=8, start -> busy for exactly 12 cycles, then done=1, vec_count=12, err_count=0.
- Corner vector 1 -> in_quad=40'hFF_FFFF_FFFF; out_quad=0 from the correct DUT gives no error.
- Faulted DUT with out_wide forced to in_wide on vector 5 only -> err_count=1, first_err_idx=5.
- Reset asserted at vector 3 -> all outputs at reset values next cycle; start then reruns from vector 0.
- STIM_SEQ_CHECK_EN undefined, faulted DUT -> err_count stays 0; vec_count still reaches 4+NUM_RAND.
